// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage RV32I core: ID-stage forwarding selects, load-use stalls,
// bubble insertion and branch flushes, driven from shadow copies of the EX and MEM slots.
module hazard_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [4:0] rd_id,
  input  logic       rs1use_id,
  input  logic       rs2use_id,
  input  logic [1:0] optype_id,
  input  logic       branch_id,
  input  logic       stall_ext,
  output logic [1:0] forward_ctrl_A,
  output logic [1:0] forward_ctrl_B,
  output logic       forward_ctrl_ls,
  output logic       PC_EN_IF,
  output logic       reg_FD_EN,
  output logic       reg_FD_flush,
  output logic       reg_DE_EN,
  output logic       reg_DE_flush,
  output logic       reg_EM_EN,
  output logic       reg_MW_EN
);

  localparam logic [1:0] OptNone  = 2'b00;
  localparam logic [1:0] OptAlu   = 2'b01;
  localparam logic [1:0] OptLoad  = 2'b10;
  localparam logic [1:0] OptStore = 2'b11;

  localparam logic [1:0] FwdRegfile = 2'b00;
  localparam logic [1:0] FwdExAlu   = 2'b01;
  localparam logic [1:0] FwdMemAlu  = 2'b10;
  localparam logic [1:0] FwdMemLoad = 2'b11;

  logic [1:0] ex_opt_q, ex_opt_d, mem_opt_q, mem_opt_d;
  logic [4:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic       ex_ls_q, ex_ls_d, mem_ls_q, mem_ls_d;

  function automatic logic writes_reg(input logic [1:0] opt, input logic [4:0] rd,
                                      input logic [4:0] r);
    return ((opt == OptAlu) || (opt == OptLoad)) && (rd == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] r,
                                         input logic [1:0] ex_opt, input logic [4:0] ex_rd,
                                         input logic [1:0] mem_opt, input logic [4:0] mem_rd);
    logic [1:0] sel;
    sel = FwdRegfile;
    if (used) begin
      if (ex_opt == OptAlu && writes_reg(ex_opt, ex_rd, r)) begin
        sel = FwdExAlu;
      end else if (mem_opt == OptAlu && writes_reg(mem_opt, mem_rd, r)) begin
        sel = FwdMemAlu;
      end else if (mem_opt == OptLoad && writes_reg(mem_opt, mem_rd, r)) begin
        sel = FwdMemLoad;
      end
    end
    return sel;
  endfunction

  logic is_store, rs2_used, ex_load, ex_wr_rs1, ex_wr_rs2;
  logic ld_stall, ls_set;

  always_comb begin
    is_store  = (optype_id == OptStore);
    rs2_used  = rs2use_id | is_store;
    ex_load   = (ex_opt_q == OptLoad);
    ex_wr_rs1 = writes_reg(ex_opt_q, ex_rd_q, rs1_id);
    ex_wr_rs2 = writes_reg(ex_opt_q, ex_rd_q, rs2_id);
    // Store data coming from a load is forwarded later in MEM, so it never stalls.
    ld_stall  = ex_load & ((rs1use_id & ex_wr_rs1) | (rs2use_id & ~is_store & ex_wr_rs2));
    ls_set    = is_store & ex_load & ex_wr_rs2;
  end

  always_comb begin
    ex_opt_d  = ex_opt_q;
    ex_rd_d   = ex_rd_q;
    ex_ls_d   = ex_ls_q;
    mem_opt_d = mem_opt_q;
    mem_rd_d  = mem_rd_q;
    mem_ls_d  = mem_ls_q;
    if (!stall_ext) begin
      mem_opt_d = ex_opt_q;
      mem_rd_d  = ex_rd_q;
      mem_ls_d  = ex_ls_q;
      if (ld_stall) begin
        ex_opt_d = OptNone;
        ex_rd_d  = 5'd0;
        ex_ls_d  = 1'b0;
      end else begin
        ex_opt_d = optype_id;
        ex_rd_d  = rd_id;
        ex_ls_d  = ls_set;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_opt_q  <= OptNone;
      ex_rd_q   <= 5'd0;
      ex_ls_q   <= 1'b0;
      mem_opt_q <= OptNone;
      mem_rd_q  <= 5'd0;
      mem_ls_q  <= 1'b0;
    end else begin
      ex_opt_q  <= ex_opt_d;
      ex_rd_q   <= ex_rd_d;
      ex_ls_q   <= ex_ls_d;
      mem_opt_q <= mem_opt_d;
      mem_rd_q  <= mem_rd_d;
      mem_ls_q  <= mem_ls_d;
    end
  end

  logic freeze, stall_act;

  // Reset forces the idle control pattern regardless of stall_ext/branch_id.
  always_comb begin
    freeze          = stall_ext & rst_n;
    stall_act       = ld_stall & rst_n & ~stall_ext;
    forward_ctrl_A  = fwd_sel(rs1use_id, rs1_id, ex_opt_q, ex_rd_q, mem_opt_q, mem_rd_q);
    forward_ctrl_B  = fwd_sel(rs2_used, rs2_id, ex_opt_q, ex_rd_q, mem_opt_q, mem_rd_q);
    forward_ctrl_ls = mem_ls_q;
    PC_EN_IF        = ~freeze & ~stall_act;
    reg_FD_EN       = ~freeze & ~stall_act;
    reg_FD_flush    = branch_id & rst_n & ~stall_ext & ~ld_stall;
    reg_DE_EN       = ~freeze;
    reg_DE_flush    = stall_act;
    reg_EM_EN       = ~freeze;
    reg_MW_EN       = ~freeze;
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed test-plan sequences plus random traffic, all checked
// against an in-flight instruction list model.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_id, rs2_id, rd_id;
  logic       rs1use_id, rs2use_id;
  logic [1:0] optype_id;
  logic       branch_id, stall_ext;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;
  logic       forward_ctrl_ls, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush;
  logic       reg_EM_EN, reg_MW_EN;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_id         (rs1_id),
    .rs2_id         (rs2_id),
    .rd_id          (rd_id),
    .rs1use_id      (rs1use_id),
    .rs2use_id      (rs2use_id),
    .optype_id      (optype_id),
    .branch_id      (branch_id),
    .stall_ext      (stall_ext),
    .forward_ctrl_A (forward_ctrl_A),
    .forward_ctrl_B (forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls),
    .PC_EN_IF       (PC_EN_IF),
    .reg_FD_EN      (reg_FD_EN),
    .reg_FD_flush   (reg_FD_flush),
    .reg_DE_EN      (reg_DE_EN),
    .reg_DE_flush   (reg_DE_flush),
    .reg_EM_EN      (reg_EM_EN),
    .reg_MW_EN      (reg_MW_EN)
  );

  // An in-flight instruction: hazard class, destination, and "store data awaits a load" flag.
  typedef struct packed {
    logic [1:0] opt;
    logic [4:0] rd;
    logic       ls;
  } instr_t;

  // inflight[0] is the instruction in EX, inflight[1] the one in MEM.
  instr_t inflight[$];

  task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic produces(input instr_t i, input logic [4:0] r);
    return (i.opt == 2'b01 || i.opt == 2'b10) && i.rd == r && r != 5'd0;
  endfunction

  function automatic logic [1:0] exp_sel(input logic used, input logic [4:0] r);
    if (!used) return 2'b00;
    if (inflight[0].opt == 2'b01 && produces(inflight[0], r)) return 2'b01;
    if (inflight[1].opt == 2'b01 && produces(inflight[1], r)) return 2'b10;
    if (inflight[1].opt == 2'b10 && produces(inflight[1], r)) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic load_use();
    if (inflight[0].opt != 2'b10) return 1'b0;
    return (rs1use_id && produces(inflight[0], rs1_id)) ||
           (rs2use_id && optype_id != 2'b11 && produces(inflight[0], rs2_id));
  endfunction

  task automatic check_outputs();
    logic stall, run;
    logic e_pc, e_de, e_def, e_em, e_fdf;
    run   = rst_n;
    stall = load_use();
    if (!run) begin
      e_pc = 1'b1; e_de = 1'b1; e_def = 1'b0; e_em = 1'b1; e_fdf = 1'b0;
    end else if (stall_ext) begin
      e_pc = 1'b0; e_de = 1'b0; e_def = 1'b0; e_em = 1'b0; e_fdf = 1'b0;
    end else if (stall) begin
      e_pc = 1'b0; e_de = 1'b1; e_def = 1'b1; e_em = 1'b1; e_fdf = 1'b0;
    end else begin
      e_pc = 1'b1; e_de = 1'b1; e_def = 1'b0; e_em = 1'b1; e_fdf = branch_id;
    end
    check_val("fwd_A", forward_ctrl_A, exp_sel(rs1use_id, rs1_id));
    check_val("fwd_B", forward_ctrl_B, exp_sel(rs2use_id || optype_id == 2'b11, rs2_id));
    check_val("fwd_ls", {1'b0, forward_ctrl_ls}, {1'b0, inflight[1].ls});
    check_val("pc_en", {1'b0, PC_EN_IF}, {1'b0, e_pc});
    check_val("fd_en", {1'b0, reg_FD_EN}, {1'b0, e_pc});
    check_val("fd_flush", {1'b0, reg_FD_flush}, {1'b0, e_fdf});
    check_val("de_en", {1'b0, reg_DE_EN}, {1'b0, e_de});
    check_val("de_flush", {1'b0, reg_DE_flush}, {1'b0, e_def});
    check_val("em_en", {1'b0, reg_EM_EN}, {1'b0, e_em});
    check_val("mw_en", {1'b0, reg_MW_EN}, {1'b0, e_em});
  endtask

  task automatic advance_model();
    instr_t nxt;
    if (stall_ext) return;
    if (load_use()) begin
      nxt = '0;
    end else begin
      nxt.opt = optype_id;
      nxt.rd  = rd_id;
      nxt.ls  = optype_id == 2'b11 && inflight[0].opt == 2'b10 && produces(inflight[0], rs2_id);
    end
    void'(inflight.pop_back());
    inflight.push_front(nxt);
  endtask

  task automatic clear_model();
    inflight.delete();
    inflight.push_back('0);
    inflight.push_back('0);
  endtask

  // Called at negedge: apply ID inputs, check, then take one clock.
  task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic u1, input logic u2, input logic [1:0] op,
                      input logic br, input logic sx);
    rs1_id = r1; rs2_id = r2; rd_id = rd; rs1use_id = u1; rs2use_id = u2;
    optype_id = op; branch_id = br; stall_ext = sx;
    #1 check_outputs();
    @(posedge clk);
    if (rst_n) advance_model();
    @(negedge clk);
  endtask

  task automatic nop();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  // Async reset mid-cycle with hostile inputs held; state must clear immediately.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    clear_model();
    branch_id = 1'b1;
    stall_ext = 1'b1;
    #1 check_outputs();
    @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_model();
    rs1_id = '0; rs2_id = '0; rd_id = '0; rs1use_id = 0; rs2use_id = 0;
    optype_id = '0; branch_id = 1'b1; stall_ext = 1'b1;
    #3 check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU-ALU back to back, then one apart
    step(5'd1, 5'd2, 5'd5, 1, 1, 2'b01, 0, 0);
    step(5'd5, 5'd5, 5'd6, 1, 1, 2'b01, 0, 0);
    step(5'd1, 5'd2, 5'd5, 1, 1, 2'b01, 0, 0);
    step(5'd1, 5'd2, 5'd10, 1, 1, 2'b01, 0, 0);
    step(5'd5, 5'd5, 5'd6, 1, 1, 2'b01, 0, 0);
    // Load-use: ID held for the bubble cycle
    step(5'd2, 5'd0, 5'd7, 1, 0, 2'b10, 0, 0);
    step(5'd7, 5'd1, 5'd8, 1, 1, 2'b01, 0, 0);
    step(5'd7, 5'd1, 5'd8, 1, 1, 2'b01, 0, 0);
    // Load feeding store data
    step(5'd2, 5'd0, 5'd9, 1, 0, 2'b10, 0, 0);
    step(5'd2, 5'd9, 5'd0, 1, 1, 2'b11, 0, 0);
    nop();
    nop();
    nop();
    // x0 never forwards; EX beats MEM
    step(5'd1, 5'd1, 5'd0, 1, 1, 2'b01, 0, 0);
    step(5'd0, 5'd0, 5'd4, 1, 1, 2'b01, 0, 0);
    step(5'd1, 5'd1, 5'd3, 1, 1, 2'b01, 0, 0);
    step(5'd1, 5'd1, 5'd3, 1, 1, 2'b01, 0, 0);
    step(5'd3, 5'd3, 5'd4, 1, 1, 2'b01, 0, 0);
    // Branch alone, then branch during load-use
    step(5'd1, 5'd2, 5'd0, 1, 1, 2'b00, 1, 0);
    nop();
    step(5'd2, 5'd0, 5'd4, 1, 0, 2'b10, 0, 0);
    step(5'd4, 5'd1, 5'd0, 1, 1, 2'b00, 1, 0);
    step(5'd4, 5'd1, 5'd0, 1, 1, 2'b00, 1, 0);
    // stall_ext over a load-use, then released
    step(5'd2, 5'd0, 5'd7, 1, 0, 2'b10, 0, 0);
    for (int i = 0; i < 3; i++) step(5'd7, 5'd1, 5'd8, 1, 1, 2'b01, 0, 1);
    step(5'd7, 5'd1, 5'd8, 1, 1, 2'b01, 0, 0);
    step(5'd7, 5'd1, 5'd8, 1, 1, 2'b01, 0, 0);
    // Reset while a store-data forward is pending and stall_ext is held
    step(5'd2, 5'd0, 5'd9, 1, 0, 2'b10, 0, 0);
    step(5'd2, 5'd9, 5'd0, 1, 1, 2'b11, 0, 0);
    step(5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 0, 0);
    step(5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 0, 1);
    reset_pulse();
    nop();
    nop();

    // Random traffic over a small register set to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end else begin
        step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 6) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline hazard controller for the 5-stage RV32I core. It tracks the hazard class and destination register of the instructions in EX and MEM in its own shadow registers. From these it produces operand-forwarding selects for ID (operand read and branch compare happen in ID), load-use stalls, bubble insertion and branch flushes. It consumes the ID-stage decode outputs `rs1use`, `rs2use` and `hazard_optype`, plus the resolved `Branch`, and drives the IF/ID and ID/EX pipeline-register controls.

## Interface
- `OPT_NONE`, 2'b00: no register write, no memory access (also bubbles and flushed slots).
- `OPT_ALU`, 2'b01: writes rd from the ALU result, which is available at the end of EX.
- `OPT_LOAD`, 2'b10: writes rd from memory data, which is available at the end of MEM.
- `OPT_STORE`, 2'b11: store; reads rs2 as store data; no rd.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rs1_id`, `rs2_id`  in  5 each  source register indices of the instruction in ID.
- `rd_id`  in  5  destination index of the instruction in ID.
- `rs1use_id`, `rs2use_id`  in  1 each  source actually read.
- `optype_id`  in  2  hazard class of the instruction in ID.
- `branch_id`  in  1  redirect taken in ID (taken branch, JAL, JALR).
- `stall_ext`  in  1  global freeze request (memory wait).
- `forward_ctrl_A`, `forward_ctrl_B`  out  2 each  ID operand select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
- `forward_ctrl_ls`  out  1  store data in MEM taken from WB load data.
- `PC_EN_IF`  out  1  PC register enable.
- `reg_FD_EN`  out  1  IF/ID enable.
- `reg_FD_flush`  out  1  IF/ID flush.
- `reg_DE_EN`  out  1  ID/EX enable.
- `reg_DE_flush`  out  1  ID/EX flush (insert bubble).
- `reg_EM_EN`, `reg_MW_EN`  out  1 each  EX/MEM and MEM/WB enables.

## Operation
- **State**: `ex_opt`/`ex_rd`, `mem_opt`/`mem_rd`, `ex_ls` and `mem_ls` (store-data forward pending). Reset clears all of them to 0 / `OPT_NONE`.
- **Writer definition**: a stage "writes r" when its opt is ALU or LOAD, its rd == r, and r != 0. A register index of 0 never creates a hazard or a forward.
- **rs2 dependence**: rs2 counts as used when `rs2use_id` is set or `optype_id` == STORE.
- **Forward select for each rs**, priority EX over MEM:
  - EX writes it with opt ALU: 01.
  - Otherwise, MEM writes it with opt ALU: 10.
  - Otherwise, MEM writes it with opt LOAD: 11.
  - Otherwise: 00.
  - An unused rs always selects 00.
- **Load-use stall**: `ld_stall` = EX opt LOAD and EX writes a used rs1, or writes rs2 used as a non-store operand.
- **Store-data exception**: when ID is STORE and its rs2 matches a LOAD in EX, there is no stall. Instead `ex_ls` is set at the next edge and propagates to `mem_ls`. `forward_ctrl_ls` = `mem_ls`.
- **Normal cycle** (no stall, no `stall_ext`):
  - All enables are 1 and `reg_DE_flush` is 0.
  - `reg_FD_flush` = `branch_id`.
  - Shadow registers advance: EX takes the ID fields, MEM takes the EX fields.
- **ld_stall cycle**:
  - `PC_EN_IF` = 0, `reg_FD_EN` = 0, `reg_DE_flush` = 1.
  - EX shadow becomes `OPT_NONE` with rd 0, and MEM takes the old EX.
  - `branch_id` is ignored: `reg_FD_flush` = 0, because the compare used stale data.
- **stall_ext**:
  - Overrides everything: all `*_EN` = 0 and both flushes = 0.
  - Shadow registers hold.
  - Forward selects are still computed from the held state.
- **Datapath contract**: flushed IF/ID and ID/EX slots present `optype` 00 with `rs*use` 0 to this block.

## Timing
- Forward selects, stall and flush outputs are combinational from the ID inputs and the shadow registers.
- Shadow registers update on the rising `clk` edge only.
- Load-use costs exactly 1 bubble. In the following cycle the load is in MEM and the select is 11.
- A taken redirect costs 1 flushed slot, on the edge after `branch_id` is seen with no stall.
- On reset assertion, asynchronous and immediate:
  - All selects are 00.
  - All enables are 1 and all flushes are 0.
  - `forward_ctrl_ls` is 0.
- Deassertion mid-program restarts with an empty shadow pipeline.

## Test plan
- **ALU-ALU**: `add x5` in ID then `sub x6,x5,x5` in the next cycle. Expect A=B=01 and no stall. With one independent instruction between them, expect 10.
- **Load-use**: `lw x7`, then `add x8,x7,x1`. Expect 1 cycle of `PC_EN_IF`=0, `reg_FD_EN`=0, `reg_DE_flush`=1. In the next cycle expect A=11 and all enables 1.
- **Load→store data**: `lw x9`, then `sw x9,0(x2)`. Expect no stall, and `forward_ctrl_ls`=1 exactly 2 cycles after the store enters ID.
- **x0 and priority**: rd=x0 ALU in EX never forwards (select 00). Both EX and MEM writing x3 gives select 01.
- **Branch**: `branch_id`=1 with no hazard gives `reg_FD_flush`=1 for 1 cycle. `branch_id`=1 together with `ld_stall` gives flush 0 and the stall taken.
- **stall_ext/reset**: `stall_ext` held for 3 cycles during a load-use gives all enables 0 and held state; the bubble is inserted only after release. `rst_n` pulsed mid-stall gives immediate reset values and a cleared `mem_ls`.
